// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer: owns the register file, decodes one instruction at a
// time and drives the shared ALU through IDLE -> READ -> EXEC -> WB.
module alu_op_sequencer #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [31:0]                 instr,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  output logic [DATA_W-1:0]           alu_a,
  output logic [DATA_W-1:0]           alu_b,
  output logic [2:0]                  alu_sel,
  input  logic [DATA_W-1:0]           alu_result,
  output logic                        done,
  output logic                        err,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]           dbg_data
);

  localparam int AW = $clog2(NUM_REGS);

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;

  localparam logic [2:0] SEL_FWD = 3'd0;
  localparam logic [2:0] SEL_ADD = 3'd1;
  localparam logic [2:0] SEL_AND = 3'd2;
  localparam logic [2:0] SEL_OR  = 3'd3;

  // ERROR is the one-cycle detour that carries the err pulse back to IDLE
  typedef enum logic [2:0] {
    IDLE,
    READ,
    EXEC,
    WB,
    ERROR
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] result_q;

  logic [7:0]        opcode;
  logic [AW-1:0]     rd;
  logic [AW-1:0]     rs1;
  logic [AW-1:0]     rs2;
  logic [DATA_W-1:0] imm;
  logic              rd_hi;
  logic              rs1_hi;
  logic              rs2_hi;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [2:0]        op_sel;
  logic              uses_rs1;
  logic              uses_rs2;
  logic              illegal;

  assign opcode = instr_q[31:24];
  assign rd     = instr_q[16 +: AW];
  assign rs1    = instr_q[8 +: AW];
  assign rs2    = instr_q[0 +: AW];
  assign imm    = DATA_W'(instr_q[7:0]);
  assign rd_hi  = (instr_q[23:16] >> AW) != 8'd0;
  assign rs1_hi = (instr_q[15:8] >> AW) != 8'd0;
  assign rs2_hi = (instr_q[7:0] >> AW) != 8'd0;

  // Operand selection and legality of the latched instruction
  always_comb begin
    op_a     = '0;
    op_b     = '0;
    op_sel   = SEL_FWD;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_LOADI: begin
        op_a = imm;
      end
      OP_MOV: begin
        op_a     = regs[rs2];
        uses_rs2 = 1'b1;
      end
      OP_ADD: begin
        op_a     = regs[rs1];
        op_b     = regs[rs2];
        op_sel   = SEL_ADD;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_SUB: begin
        op_a     = regs[rs1];
        op_b     = (~regs[rs2]) + DATA_W'(1);
        op_sel   = SEL_ADD;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_AND: begin
        op_a     = regs[rs1];
        op_b     = regs[rs2];
        op_sel   = SEL_AND;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_OR: begin
        op_a     = regs[rs1];
        op_b     = regs[rs2];
        op_sel   = SEL_OR;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
    if (rd_hi || (uses_rs1 && rs1_hi) || (uses_rs2 && rs2_hi)) begin
      illegal = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_nx = READ;
        end
      end
      READ: begin
        state_nx = illegal ? ERROR : EXEC;
      end
      EXEC: begin
        state_nx = WB;
      end
      WB: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      ERROR: begin
        err      = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= '0;
    end else if (state == IDLE && instr_valid) begin
      instr_q <= instr;
    end
  end

  // ALU inputs only change on a legal decode, so they hold across errors and idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= SEL_FWD;
    end else if (state == READ && !illegal) begin
      alu_a   <= op_a;
      alu_b   <= op_b;
      alu_sel <= op_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
    end else if (state == EXEC) begin
      result_q <= alu_result;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (state == WB) begin
      regs[rd] <= result_q;
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus predicts each retirement from
// an architectural model, a monitor pops and compares on every done/err pulse.
module tb_alu_op_sequencer;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_result;
  logic        done;
  logic        err;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  alu_op_sequencer #(.NUM_REGS(8), .DATA_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_result  (alu_result),
    .done        (done),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // The shared ALU the sequencer drives
  always_comb begin
    case (alu_sel)
      3'd0:    alu_result = alu_a;
      3'd1:    alu_result = alu_a + alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    int         acc;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mem [8];
  logic [7:0] last_a;
  logic [7:0] last_b;
  logic [2:0] last_sel;
  int         last_acc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2);
    return {op[7:0], rd[7:0], rs1[7:0], rs2[7:0]};
  endfunction

  // Architectural effect of one instruction on the model register file
  task automatic predict(input logic [31:0] w, output exp_t e);
    int op  = int'(w[31:24]);
    int rd  = int'(w[23:16]);
    int rs1 = int'(w[15:8]);
    int rs2 = int'(w[7:0]);
    int x, y, res;
    bit bad;
    bad = (op > 5) || (rd > 7) || (op >= 2 && rs1 > 7) || (op >= 1 && rs2 > 7);
    e.is_err = bad;
    if (bad) begin
      e.a = last_a; e.b = last_b; e.sel = last_sel;
      return;
    end
    x = (op >= 2) ? int'(mem[rs1]) : 0;
    y = (op >= 1) ? int'(mem[rs2]) : rs2;
    case (op)
      0: begin res = rs2;               e.a = rs2[7:0]; e.b = 8'h00;            e.sel = 3'd0; end
      1: begin res = y;                 e.a = y[7:0];   e.b = 8'h00;            e.sel = 3'd0; end
      2: begin res = (x + y) % 256;     e.a = x[7:0];   e.b = y[7:0];           e.sel = 3'd1; end
      3: begin res = (x - y + 256) % 256; e.a = x[7:0]; e.b = 8'((256 - y) % 256); e.sel = 3'd1; end
      4: begin res = x & y;             e.a = x[7:0];   e.b = y[7:0];           e.sel = 3'd2; end
      default: begin res = x | y;       e.a = x[7:0];   e.b = y[7:0];           e.sel = 3'd3; end
    endcase
    mem[rd] = res[7:0];
    last_a = e.a; last_b = e.b; last_sel = e.sel;
  endtask

  // Presents w and returns right after the accepting edge with valid still high
  task automatic applyStimulus(input logic [31:0] w);
    exp_t e;
    int n = 0;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_wait", instr_ready, 1);
    if (!instr_ready) begin
      instr_valid = 1'b0;
      return;
    end
    predict(w, e);
    e.acc = cyc;
    last_acc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    instr_valid = 1'b0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_empty", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic checkRegs();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0];
      #1;
      checkOutput($sformatf("dbg_r%0d", i), dbg_data, mem[i]);
    end
  endtask

  task automatic readReg(input int r, output logic [7:0] v);
    dbg_addr = r[2:0];
    #1;
    v = dbg_data;
  endtask

  task automatic resetModel();
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    last_a = 8'h00; last_b = 8'h00; last_sel = 3'd0;
    exp_q.delete();
  endtask

  // Monitor: every retirement pulse must match the oldest prediction
  always @(negedge clk) begin
    if (reset_n) begin
      if (done && err) checkOutput("done_and_err", {done, err}, 0);
      if (done || err) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pulse", {done, err}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("done_kind", done, !e.is_err);
          checkOutput("err_kind", err, e.is_err);
          checkOutput("latency", cyc - e.acc, e.is_err ? 2 : 3);
          checkOutput("alu_a", alu_a, e.a);
          checkOutput("alu_b", alu_b, e.b);
          checkOutput("alu_sel", alu_sel, e.sel);
        end
      end
    end
  end

  initial begin
    logic [7:0] v;
    int prev;
    reset_n = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    dbg_addr = '0;
    resetModel();
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", instr_ready, 1);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_sel", alu_sel, 0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_ready", instr_ready, 1);
    checkOutput("rel_alu_a", alu_a, 0);
    checkOutput("rel_alu_b", alu_b, 0);
    checkRegs();

    applyStimulus(mk(0, 1, 0, 7));
    applyStimulus(mk(0, 2, 0, 3));
    applyStimulus(mk(2, 3, 1, 2));
    applyStimulus(mk(4, 4, 1, 2));
    applyStimulus(mk(5, 5, 1, 2));
    drain();
    readReg(3, v); checkOutput("plan_add_r3", v, 8'd10);
    readReg(4, v); checkOutput("plan_and_r4", v, 8'd3);
    readReg(5, v); checkOutput("plan_or_r5", v, 8'd7);

    applyStimulus(mk(0, 1, 0, 8'hFF));
    applyStimulus(mk(0, 2, 0, 8'h02));
    applyStimulus(mk(2, 6, 1, 2));
    applyStimulus(mk(3, 7, 2, 1));
    drain();
    readReg(6, v); checkOutput("plan_wrap_r6", v, 8'h01);
    readReg(7, v); checkOutput("plan_sub_r7", v, 8'h03);
    checkOutput("plan_sub_alu_b", alu_b, 8'h01);

    applyStimulus(mk(9, 1, 2, 3));
    prev = last_acc;
    applyStimulus(mk(2, 8, 1, 2));
    checkOutput("err_reaccept", last_acc - prev, 3);
    drain();
    checkRegs();

    applyStimulus(mk(1, 0, 0, 1));
    for (int i = 0; i < 6; i++) begin
      prev = last_acc;
      applyStimulus(mk(1, (i + 1) % 8, 0, i % 8));
      checkOutput("b2b_spacing", last_acc - prev, 4);
    end
    drain();
    checkRegs();

    for (int i = 0; i < 150; i++) begin
      int op, rd, rs1, rs2;
      op  = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 255) : $urandom_range(0, 5);
      rd  = ($urandom_range(0, 15) == 0) ? $urandom_range(8, 255) : $urandom_range(0, 7);
      rs1 = ($urandom_range(0, 15) == 0) ? $urandom_range(8, 255) : $urandom_range(0, 7);
      rs2 = (op == 0 || $urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
      applyStimulus(mk(op, rd, rs1, rs2));
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        instr_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drain();
    checkRegs();

    applyStimulus(mk(0, 1, 0, 8'h21));
    applyStimulus(mk(0, 2, 0, 8'h12));
    applyStimulus(mk(2, 3, 1, 2));
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("exec_sel_add", alu_sel, 3'd1);
    #2;
    reset_n = 1'b0;
    resetModel();
    #1;
    checkOutput("async_done", done, 0);
    checkOutput("async_err", err, 0);
    checkOutput("async_ready", instr_ready, 1);
    checkOutput("async_alu_a", alu_a, 0);
    checkOutput("async_alu_b", alu_b, 0);
    checkOutput("async_alu_sel", alu_sel, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    readReg(3, v); checkOutput("abort_r3", v, 8'h00);
    checkRegs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle controller that owns an 8-entry x 8-bit register file and sequences the shared 8-bit ALU (select codes 0:FORWARD, 1:ADD, 2:AND, 3:OR). It accepts one 32-bit instruction through a valid/ready handshake, reads the operands and drives the ALU's A, B and select inputs. It captures the ALU result and writes it back to the register file. It sits between the instruction source and the ALU, and is the only block that drives the ALU's inputs.

Parameters:
NUM_REGS, 8, register file depth; must be a power of two, and only the low log2(NUM_REGS) bits of each register field are used.
DATA_W, 8, datapath width; must match the ALU width.

Ports:
clk  input  1  single system clock; rising edge.
reset_n  input  1  asynchronous active-low reset.
instr  input  32  instruction word: [31:24] opcode, [23:16] rd, [15:8] rs1, [7:0] rs2 or immediate.
instr_valid  input  1  instr is presented this cycle.
instr_ready  output  1  sequencer can accept an instruction this cycle.
alu_a  output  DATA_W  ALU operand A.
alu_b  output  DATA_W  ALU operand B.
alu_sel  output  3  ALU select code.
alu_result  input  DATA_W  ALU result; combinational from alu_a, alu_b and alu_sel.
done  output  1  one-cycle pulse: instruction retired with writeback.
err  output  1  one-cycle pulse: instruction rejected with no writeback.
dbg_addr  input  3  debug read address.
dbg_data  output  DATA_W  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE; all registers = 0.
  - alu_a = alu_b = 0, alu_sel = 0.
  - done = err = 0; instr_ready = 1 in the first cycle after release.
- Reset asserted mid-instruction aborts it immediately: no writeback, no done or err pulse.
- Opcodes:
  - 0 LOADI: rd = imm. Select 0, A = imm.
  - 1 MOV: rd = rs2. Select 0, A = R[rs2].
  - 2 ADD: select 1, A = R[rs1], B = R[rs2].
  - 3 SUB: select 1, A = R[rs1], B = (~R[rs2]) + 1, computed mod 2^8 inside the sequencer.
  - 4 AND: select 2.
  - 5 OR: select 3.
  - Opcodes 6..255 are illegal.
- Arithmetic: all results are mod 2^8. Carry and borrow are discarded; there are no flags.
- Register fields: only bits [2:0] are used. If bits [7:3] of any used register field are nonzero, the instruction is illegal. rs1 is unused for LOADI and MOV; rs1 and rs2 are unused for LOADI.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
  - IDLE: instr_ready = 1. On instr_valid && instr_ready, latch instr and go to READ. Ready is low in all other states.
  - READ: decode. If illegal, pulse err next cycle and return to IDLE; the ALU outputs hold their previous values. If legal, register alu_a, alu_b and alu_sel from the register file and go to EXEC.
  - EXEC: ALU inputs are stable; capture alu_result into the result register at the end of this cycle; go to WB.
  - WB: write the result to R[rd] on the clock edge; done = 1 for this cycle; go to IDLE.
- Timing, with the handshake accepted at edge 0:
  - alu_* valid after edge 1.
  - Result captured at edge 2.
  - done high during cycle 3; the write commits at edge 3.
  - instr_ready is high again in cycle 4.
  - Throughput: one instruction per 4 cycles.
  - An illegal instruction takes 2 cycles: err is high during cycle 2 and ready returns in cycle 3.
- alu_a, alu_b and alu_sel are registered and hold their values between instructions; LOADI and MOV drive B = 0.
- Read-after-write: the next instruction is always accepted after the previous writeback has committed, so no forwarding is needed.
- rd == rs1 == rs2 is legal; operands are read before the write.
- dbg_data reflects a write on the cycle after the WB edge.
- instr_valid while ready is low is ignored; the source must hold instr and instr_valid until the handshake completes.
- done and err are never high together.

Test Plan:
1. Release reset, then read dbg registers 0..7 -> all read 0. instr_ready = 1, done = 0, alu_sel = 0.
2. Send LOADI r1,7; LOADI r2,3; ADD r3,r1,r2; AND r4,r1,r2; OR r5,r1,r2 -> dbg reads r3 = 10, r4 = 3, r5 = 7. Each done pulse arrives exactly 3 cycles after its handshake. For the ADD, alu_sel = 1 during EXEC.
3. Send LOADI r1,0xFF; LOADI r2,0x02; ADD r6,r1,r2; SUB r7,r2,r1 -> r6 = 0x01 (wrap). r7 = 0x03, with alu_b = 0x01 during EXEC.
4. Send opcode 0x09, then ADD with rd = 0x08 -> each gives an err pulse 2 cycles after its handshake, with no register change and no done pulse.
5. Hold instr_valid high continuously with back-to-back MOV instructions -> instr_ready is high only in IDLE, giving exactly one acceptance per 4 cycles.
6. Assert reset_n low during EXEC of ADD r3 -> r3 stays 0 and no done pulse occurs. All outputs return to their reset values asynchronously, before the next clock edge.
